// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: registered state, outputs decoded from state (plus Mem_Ready gating).
// Optional multiply stall enabled by defining MIPS_MULT_STALL_EN.
module mips_multicycle_ctrl #(
    parameter int MUL_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Mem_Ready,
    output logic       PC_Write,
    output logic       PC_Write_Cond,
    output logic       IorD,
    output logic       Mem_Write,
    output logic       IR_Write,
    output logic       Mem_to_Reg,
    output logic       Reg_Dst,
    output logic       Reg_Write,
    output logic       ALU_Src_A,
    output logic [1:0] ALU_Src_B,
    output logic [1:0] PC_Src,
    output logic [1:0] ALU_Op,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_MULWAIT = 4'd12
    } state_e;

    state_e state_q, state_d;

    generate
        if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
            $error("MUL_CYCLES must be within 2..15");
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= S_FETCH;
        else      state_q <= state_d;
    end

`ifdef MIPS_MULT_STALL_EN
    logic [3:0] cnt_q, cnt_d;
    logic       is_mul;

    assign is_mul = (Funct == 6'b011100);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) cnt_q <= 4'd0;
        else      cnt_q <= cnt_d;
    end
`else
    logic unused_funct;
    assign unused_funct = ^Funct;
`endif

    assign State = state_q;

    always_comb begin
        state_d       = S_FETCH;
        PC_Write      = 1'b0;
        PC_Write_Cond = 1'b0;
        IorD          = 1'b0;
        Mem_Write     = 1'b0;
        IR_Write      = 1'b0;
        Mem_to_Reg    = 1'b0;
        Reg_Dst       = 1'b0;
        Reg_Write     = 1'b0;
        ALU_Src_A     = 1'b0;
        ALU_Src_B     = 2'b00;
        PC_Src        = 2'b00;
        ALU_Op        = 2'b00;
`ifdef MIPS_MULT_STALL_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                ALU_Src_B = 2'b01;
                IR_Write  = Mem_Ready;
                PC_Write  = Mem_Ready;
                state_d   = Mem_Ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALU_Src_B = 2'b11;
                case (Opcode)
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000000:            state_d = S_EXEC;
                    6'b000100:            state_d = S_BRANCH;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default:              state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
                state_d   = (Opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                state_d = Mem_Ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                Mem_to_Reg = 1'b1;
                Reg_Write  = 1'b1;
            end
            S_MEMWR: begin
                IorD      = 1'b1;
                Mem_Write = Mem_Ready;
                state_d   = Mem_Ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALU_Src_A = 1'b1;
                ALU_Op    = 2'b10;
                state_d   = S_ALUWB;
`ifdef MIPS_MULT_STALL_EN
                if (is_mul) begin
                    cnt_d   = 4'(MUL_CYCLES - 1);
                    state_d = S_MULWAIT;
                end
`endif
            end
`ifdef MIPS_MULT_STALL_EN
            S_MULWAIT: begin
                ALU_Src_A = 1'b1;
                ALU_Op    = 2'b10;
                cnt_d     = cnt_q - 4'd1;
                state_d   = (cnt_q == 4'd0) ? S_ALUWB : S_MULWAIT;
            end
`endif
            S_ALUWB: begin
                Reg_Dst   = 1'b1;
                Reg_Write = 1'b1;
            end
            S_BRANCH: begin
                ALU_Src_A     = 1'b1;
                ALU_Op        = 2'b01;
                PC_Src        = 2'b01;
                PC_Write_Cond = 1'b1;
            end
            S_ADDIEX: begin
                ALU_Src_A = 1'b1;
                ALU_Src_B = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: Reg_Write = 1'b1;
            S_JUMP: begin
                PC_Src   = 2'b10;
                PC_Write = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset must also silence FETCH's Mem_Ready-driven enables.
        if (!RST) begin
            PC_Write      = 1'b0;
            PC_Write_Cond = 1'b0;
            Mem_Write     = 1'b0;
            IR_Write      = 1'b0;
            Reg_Write     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; outputs sampled on the falling clock edge.
module tb_mips_multicycle_ctrl;

    logic       CLK, RST;
    logic [5:0] Opcode, Funct;
    logic       Mem_Ready;
    logic       PC_Write, PC_Write_Cond, IorD, Mem_Write, IR_Write;
    logic       Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A;
    logic [1:0] ALU_Src_B, PC_Src, ALU_Op;
    logic [3:0] State;

    int total = 0;
    int bad   = 0;

    mips_multicycle_ctrl #(.MUL_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .Opcode(Opcode), .Funct(Funct), .Mem_Ready(Mem_Ready),
        .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
        .Mem_Write(Mem_Write), .IR_Write(IR_Write), .Mem_to_Reg(Mem_to_Reg),
        .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write), .ALU_Src_A(ALU_Src_A),
        .ALU_Src_B(ALU_Src_B), .PC_Src(PC_Src), .ALU_Op(ALU_Op), .State(State)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Each scenario task starts just after a falling edge with State=FETCH and ends the same way.
    task automatic test_reset();
        logic [4:0] en;
        RST = 1'b0; Mem_Ready = 1'b1; Opcode = 6'b000000; Funct = 6'b000000;
        #2;
        en = {PC_Write, PC_Write_Cond, Mem_Write, IR_Write, Reg_Write};
        total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", State); end
        total++; if (en !== 5'b0) begin bad++; $display("FAIL reset_enables got=%b exp=00000", en); end
        @(negedge CLK);
        RST = 1'b1; Mem_Ready = 1'b0;
        #1;
        total++; if (IR_Write !== 1'b0 || PC_Write !== 1'b0) begin bad++; $display("FAIL fetch_wait_en got=%b%b exp=00", IR_Write, PC_Write); end
        @(negedge CLK);
        total++; if (State !== 4'd0) begin bad++; $display("FAIL fetch_hold got=%0d exp=0", State); end
        Mem_Ready = 1'b1;
        #1;
        total++; if (IR_Write !== 1'b1 || PC_Write !== 1'b1) begin bad++; $display("FAIL fetch_ready_en got=%b%b exp=11", IR_Write, PC_Write); end
        total++; if (ALU_Src_B !== 2'b01 || IorD !== 1'b0) begin bad++; $display("FAIL fetch_sel got=%b/%b exp=01/0", ALU_Src_B, IorD); end
    endtask

    task automatic test_lw();
        logic [3:0] es [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        Opcode = 6'b100011; Mem_Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            total++; if (State !== es[i]) begin bad++; $display("FAIL lw_state step=%0d got=%0d exp=%0d", i, State, es[i]); end
            total++; if (Reg_Write !== (es[i] == 4'd4)) begin bad++; $display("FAIL lw_regwrite step=%0d got=%b", i, Reg_Write); end
            if (es[i] == 4'd4) begin
                total++; if (Mem_to_Reg !== 1'b1 || Reg_Dst !== 1'b0) begin bad++; $display("FAIL lw_wb_sel got=%b%b exp=10", Mem_to_Reg, Reg_Dst); end
            end
            if (es[i] == 4'd2) begin
                total++; if (ALU_Src_A !== 1'b1 || ALU_Src_B !== 2'b10) begin bad++; $display("FAIL lw_memadr got=%b/%b exp=1/10", ALU_Src_A, ALU_Src_B); end
            end
            if (es[i] == 4'd3) begin
                total++; if (IorD !== 1'b1) begin bad++; $display("FAIL lw_iord got=%b exp=1", IorD); end
            end
        end
    endtask

    task automatic test_sw_wait();
        Opcode = 6'b101011; Mem_Ready = 1'b1;
        @(negedge CLK);
        total++; if (State !== 4'd1) begin bad++; $display("FAIL sw_decode got=%0d exp=1", State); end
        @(negedge CLK);
        total++; if (State !== 4'd2) begin bad++; $display("FAIL sw_memadr got=%0d exp=2", State); end
        Mem_Ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            total++; if (State !== 4'd5 || Mem_Write !== 1'b0) begin bad++; $display("FAIL sw_wait cyc=%0d got=%0d/%b exp=5/0", i, State, Mem_Write); end
        end
        @(posedge CLK);
        #1 Mem_Ready = 1'b1;
        @(negedge CLK);
        total++; if (State !== 4'd5 || Mem_Write !== 1'b1 || IorD !== 1'b1) begin bad++; $display("FAIL sw_write got=%0d/%b/%b exp=5/1/1", State, Mem_Write, IorD); end
        @(negedge CLK);
        total++; if (State !== 4'd0 || Mem_Write !== 1'b0) begin bad++; $display("FAIL sw_done got=%0d/%b exp=0/0", State, Mem_Write); end
    endtask

    task automatic test_rtype();
        logic [3:0] es [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
        Opcode = 6'b000000; Funct = 6'b100000; Mem_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++; if (State !== es[i]) begin bad++; $display("FAIL rtype_state step=%0d got=%0d exp=%0d", i, State, es[i]); end
            if (es[i] == 4'd6) begin
                total++; if (ALU_Op !== 2'b10 || ALU_Src_A !== 1'b1 || ALU_Src_B !== 2'b00) begin bad++; $display("FAIL rtype_exec got=%b/%b/%b exp=10/1/00", ALU_Op, ALU_Src_A, ALU_Src_B); end
            end
            if (es[i] == 4'd7) begin
                total++; if (Reg_Write !== 1'b1 || Reg_Dst !== 1'b1 || Mem_to_Reg !== 1'b0) begin bad++; $display("FAIL rtype_wb got=%b%b%b exp=110", Reg_Write, Reg_Dst, Mem_to_Reg); end
            end
        end
    endtask

    task automatic test_addi();
        logic [3:0] es [4] = '{4'd1, 4'd9, 4'd10, 4'd0};
        Opcode = 6'b001000; Mem_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++; if (State !== es[i]) begin bad++; $display("FAIL addi_state step=%0d got=%0d exp=%0d", i, State, es[i]); end
            if (es[i] == 4'd10) begin
                total++; if (Reg_Write !== 1'b1 || Reg_Dst !== 1'b0) begin bad++; $display("FAIL addi_wb got=%b%b exp=10", Reg_Write, Reg_Dst); end
            end
        end
    endtask

    task automatic test_branch_jump();
        Opcode = 6'b000100; Mem_Ready = 1'b1;
        @(negedge CLK);
        total++; if (State !== 4'd1 || ALU_Src_B !== 2'b11) begin bad++; $display("FAIL beq_decode got=%0d/%b exp=1/11", State, ALU_Src_B); end
        @(negedge CLK);
        total++; if (State !== 4'd8) begin bad++; $display("FAIL beq_state got=%0d exp=8", State); end
        total++; if (ALU_Op !== 2'b01 || PC_Src !== 2'b01 || PC_Write_Cond !== 1'b1 || PC_Write !== 1'b0) begin bad++; $display("FAIL beq_out got=%b/%b/%b%b exp=01/01/10", ALU_Op, PC_Src, PC_Write_Cond, PC_Write); end
        Opcode = 6'b000010;
        @(negedge CLK);
        total++; if (State !== 4'd0) begin bad++; $display("FAIL beq_done got=%0d exp=0", State); end
        @(negedge CLK);
        @(negedge CLK);
        total++; if (State !== 4'd11) begin bad++; $display("FAIL j_state got=%0d exp=11", State); end
        total++; if (PC_Src !== 2'b10 || PC_Write !== 1'b1 || PC_Write_Cond !== 1'b0) begin bad++; $display("FAIL j_out got=%b/%b%b exp=10/10", PC_Src, PC_Write, PC_Write_Cond); end
        @(negedge CLK);
        total++; if (State !== 4'd0) begin bad++; $display("FAIL j_done got=%0d exp=0", State); end
    endtask

    task automatic test_mul();
`ifdef MIPS_MULT_STALL_EN
        logic [3:0] es [8] = '{4'd1, 4'd6, 4'd12, 4'd12, 4'd12, 4'd12, 4'd7, 4'd0};
        localparam int N = 8;
`else
        logic [3:0] es [4] = '{4'd1, 4'd6, 4'd7, 4'd0};
        localparam int N = 4;
`endif
        Opcode = 6'b000000; Funct = 6'b011100; Mem_Ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            @(negedge CLK);
            total++; if (State !== es[i]) begin bad++; $display("FAIL mul_state step=%0d got=%0d exp=%0d", i, State, es[i]); end
            if (es[i] == 4'd12) begin
                total++; if (ALU_Op !== 2'b10 || ALU_Src_A !== 1'b1 || Reg_Write !== 1'b0) begin bad++; $display("FAIL mul_wait_out got=%b/%b/%b exp=10/1/0", ALU_Op, ALU_Src_A, Reg_Write); end
            end
        end
        Funct = 6'b000000;
    endtask

    task automatic test_reset_midop();
        logic [4:0] en;
        Opcode = 6'b100011; Mem_Ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        Mem_Ready = 1'b0;
        @(negedge CLK);
        total++; if (State !== 4'd3) begin bad++; $display("FAIL midrst_pre got=%0d exp=3", State); end
        @(negedge CLK);
        total++; if (State !== 4'd3) begin bad++; $display("FAIL midrst_hold got=%0d exp=3", State); end
        #2 Mem_Ready = 1'b1; RST = 1'b0;
        #1;
        en = {PC_Write, PC_Write_Cond, Mem_Write, IR_Write, Reg_Write};
        total++; if (State !== 4'd0) begin bad++; $display("FAIL midrst_state got=%0d exp=0", State); end
        total++; if (en !== 5'b0 || IorD !== 1'b0) begin bad++; $display("FAIL midrst_en got=%b/%b exp=00000/0", en, IorD); end
        @(negedge CLK);
        total++; if (State !== 4'd0) begin bad++; $display("FAIL midrst_held got=%0d exp=0", State); end
        RST = 1'b1;
    endtask

    task automatic test_illegal();
        logic [4:0] en;
        Opcode = 6'b111111; Mem_Ready = 1'b1;
        @(negedge CLK);
        en = {PC_Write, PC_Write_Cond, Mem_Write, IR_Write, Reg_Write};
        total++; if (State !== 4'd1) begin bad++; $display("FAIL ill_decode got=%0d exp=1", State); end
        total++; if (en !== 5'b0) begin bad++; $display("FAIL ill_en got=%b exp=00000", en); end
        @(negedge CLK);
        total++; if (State !== 4'd0) begin bad++; $display("FAIL ill_back got=%0d exp=0", State); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_addi();
        test_branch_jump();
        test_mul();
        test_reset_midop();
        test_illegal();
        test_lw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
MIPS_MULTICYCLE_CTRL -- requirements
Module: mips_multicycle_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, multiply stall length in cycles; legal range 2..15.
REQ-002 SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port Opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port Funct, input, 6, instruction bits [5:0].
REQ-006 SHALL have port Mem_Ready, input, 1, memory access completes in the cycle it is high.
REQ-007 SHALL have outputs PC_Write, PC_Write_Cond, IorD, Mem_Write, IR_Write, Mem_to_Reg, Reg_Dst, Reg_Write, ALU_Src_A: each 1 bit, datapath enables and mux selects.
REQ-008 SHALL have outputs ALU_Src_B, PC_Src, ALU_Op: each 2 bits; ALU_Op drives the existing ALU decoder (00 add, 01 sub, 10 by funct).
REQ-009 SHALL have output State, 4 bits, current state code, for debug.

Function
REQ-010 SHALL be a registered-state FSM with combinational outputs. Each output is a function of state only, except the Mem_Ready gating in REQ-012.
REQ-011 SHALL use these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, MULWAIT=12.
REQ-012 SHALL handle FETCH as follows:
- Outputs: IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=00, PC_Src=00.
- IR_Write=PC_Write=Mem_Ready.
- Stay in FETCH while Mem_Ready=0; go to DECODE when Mem_Ready=1.
REQ-013 SHALL handle DECODE with ALU_Src_A=0, ALU_Src_B=11, ALU_Op=00, then dispatch on Opcode:
- 100011 or 101011 -> MEMADR
- 000000 -> EXEC
- 000100 -> BRANCH
- 001000 -> ADDIEX
- 000010 -> JUMP
- any other value -> FETCH (executes as a NOP)
REQ-014 SHALL handle MEMADR with ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00; next state is MEMRD if Opcode=100011, else MEMWR.
REQ-015 SHALL handle MEMRD with IorD=1; it holds until Mem_Ready=1, then goes to MEMWB.
REQ-016 SHALL handle MEMWB with Reg_Dst=0, Mem_to_Reg=1, Reg_Write=1; next state FETCH.
REQ-017 SHALL handle MEMWR with IorD=1 and Mem_Write=Mem_Ready; it holds until Mem_Ready=1, then goes to FETCH.
REQ-018 SHALL handle EXEC with ALU_Src_A=1, ALU_Src_B=00, ALU_Op=10; next state ALUWB, except as modified by REQ-030.
REQ-019 SHALL handle ALUWB with Reg_Dst=1, Mem_to_Reg=0, Reg_Write=1; next state FETCH.
REQ-020 SHALL handle BRANCH with ALU_Src_A=1, ALU_Src_B=00, ALU_Op=01, PC_Src=01, PC_Write_Cond=1; next state FETCH.
REQ-021 SHALL handle ADDIEX with ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00, next state ADDIWB; ADDIWB has Reg_Dst=0, Mem_to_Reg=0, Reg_Write=1, next state FETCH.
REQ-022 SHALL handle JUMP with PC_Src=10, PC_Write=1; next state FETCH.
REQ-023 SHALL drive every enable not listed for a state to 0, and every select not listed to 0.
REQ-024 SHALL send any unused state code (13..15) to FETCH on the next edge, with all enables 0 while in it.
REQ-025 SHALL produce these instruction latencies, in cycles, from FETCH entry to the next FETCH entry, with Mem_Ready held at 1:
- lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-026 SHALL force State=FETCH and clear the multiply counter immediately while RST=0, regardless of CLK.
REQ-027 SHALL drive PC_Write, PC_Write_Cond, Mem_Write, IR_Write and Reg_Write to 0 while RST=0, overriding FETCH decoding.
REQ-028 SHALL abandon any in-flight instruction, including a pending MULWAIT, on reset; the first edge after release evaluates FETCH.

Configuration
REQ-029 SHALL honour macro MIPS_MULT_STALL_EN.
REQ-030 SHALL, with MIPS_MULT_STALL_EN defined:
- EXEC with Funct=011100 loads a 4-bit counter with MUL_CYCLES-1 and goes to MULWAIT.
- MULWAIT holds the EXEC outputs and decrements the counter each cycle.
- MULWAIT goes to ALUWB in the cycle the counter equals 0.
- The mul instruction therefore takes 4+MUL_CYCLES cycles.
REQ-031 SHALL, without MIPS_MULT_STALL_EN: never reach MULWAIT, have EXEC always go to ALUWB, exclude the counter from synthesis, and ignore MUL_CYCLES.

Verification
REQ-032 SHALL cover a lw sequence: Opcode=100011, Mem_Ready=1 -> State 0,1,2,3,4,0; Reg_Write=1 only in state 4, with Mem_to_Reg=1.
REQ-033 SHALL cover memory wait: sw with Mem_Ready low for 3 cycles in MEMWR -> State holds at 5 for 3 cycles with Mem_Write=0; Mem_Write=1 for exactly one cycle, then State=0.
REQ-034 SHALL cover beq and j: Opcode=000100 -> ALU_Op=01, PC_Src=01, PC_Write_Cond=1 in state 8; Opcode=000010 -> PC_Src=10, PC_Write=1 in state 11.
REQ-035 SHALL cover multiply stall: macro defined, MUL_CYCLES=4, Opcode=000000, Funct=011100 -> State 6, then 12 for 4 cycles, then 7, then 0; total 8 cycles.
REQ-036 SHALL cover reset mid-operation and illegal opcode:
- RST low asynchronously while State=3 -> State=0 and all enables 0 before the next CLK edge.
- Opcode=111111 -> DECODE goes to FETCH with no write enable asserted.
